uart_rxser: RTL and testbench
=============================

# uart_rxser

Serial receive front-end for the 6850-compatible UART: oversamples the asynchronous RXD line at CLK/16, deframes 8n1 characters, buffers them in a small FIFO and presents them on the host-side handshake that feeds the UART data register (`host_rd` / `host_dout` / `host_dor`). It also generates the `cts` flow-control level that the UART inverts onto CTS_B, and reports framing and overrun errors.

## Interface
- `CLKS_PER_BIT`, 16, clocks per serial bit; even, ≥ 4.
- `FIFO_DEPTH`, 4, receive FIFO entries; power of 2, ≥ 2.
- `clk`  in  1  system clock. All state updates on the falling edge, matching the UART host register timing.
- `reset_b`  in  1  reset, synchronous, active-low.
- `serin`  in  1  asynchronous serial input; idle high.
- `host_rd`  in  1  level-high host data-register read strobe; may stay high for several cycles.
- `host_dout`  out  8  FIFO head byte; 0x00 when the FIFO is empty.
- `host_dor`  out  1  data output ready (FIFO not empty).
- `cts`  out  1  clear-to-send; high while the FIFO has room for more than one character.
- `frame_err`  out  1  sticky: stop bit was sampled low.
- `overrun`  out  1  sticky: a character arrived while the FIFO was full.

## Operation
- Synchroniser: `serin` passes through 2 flops, both reset to 1. All decisions use the synchronised `rxs`.
- The bit counter runs 0..CLKS_PER_BIT-1. The bit index runs 0..7.
- States:
  - IDLE: `rxs` = 0 → START, counter cleared.
  - START: when counter reaches CLKS_PER_BIT/2-1 (mid start bit):
    - `rxs` = 0 → DATA, counter and index cleared.
    - `rxs` = 1 → IDLE (glitch rejected).
  - DATA: when counter reaches CLKS_PER_BIT-1, shift `rxs` into the shift register MSB (LSB-first line order), counter cleared. After index 7 → STOP.
  - STOP: when counter reaches CLKS_PER_BIT-1:
    - `rxs` = 1 → push the shift register into the FIFO, then IDLE.
    - `rxs` = 0 → set `frame_err`, discard the byte, go to WAIT_HI.
  - WAIT_HI: stay until `rxs` = 1, then IDLE. A held break yields exactly one frame error.
- Push while the FIFO is full: byte dropped, `overrun` set, FIFO contents unchanged.
- Pop:
  - Triggered once per read access, on the first cycle `host_rd` = 0 following a cycle with `host_rd` = 1. Detection uses a registered copy `host_rd_q`.
  - `host_dout` is therefore stable for the whole read.
  - A pop when the FIFO is empty is ignored.
- Any pop event (including an ignored one) clears `frame_err` and `overrun`. A set in the same cycle wins.
- Push and pop in the same cycle:
  - Both take effect; count unchanged.
  - If the FIFO was full, the push is accepted and no overrun is flagged.
- Count width is clog2(FIFO_DEPTH)+1. Read and write pointers wrap modulo FIFO_DEPTH.
- `cts` is registered: next value = (next count < FIFO_DEPTH-1).
- Reset (`reset_b` low at a falling clk edge) values:
  - FSM → IDLE; counter, index, pointers, count → 0.
  - `host_dor` 0, `host_dout` 0x00, `cts` 1, `frame_err` 0, `overrun` 0.
  - A reset mid-character abandons the character. FIFO storage is not reset.

## Timing
- Start edge on `serin` → `rxs` low: 2 clk.
- Start bit sampled CLKS_PER_BIT/2 clk after `rxs` falls. Each later sample is CLKS_PER_BIT clk apart.
- Full frame is 10·CLKS_PER_BIT clk (160 at default). The receiver is back in IDLE at the stop-bit midpoint, giving ½-bit margin for back-to-back frames.
- Stop sample → `host_dor` = 1 and `host_dout` valid: next falling edge (1 clk).
- `host_rd` falling → pointer advance: 1 clk. New `host_dout` / `host_dor` / `cts` are visible on that same edge.
- `frame_err` / `overrun` assert 1 clk after the stop sample.

## Structure
- Shared package `uart_pkg`:
  - FSM state enum (IDLE, START, DATA, STOP, WAIT_HI).
  - Default constants CLKS_PER_BIT=16, FIFO_DEPTH=4; also used by `uarttx` for the fixed CLK/16 rate.
- One sub-module, `uart_rxfifo`:
  - Synchronous FIFO with push/pop/full/empty/count and a registered CTS threshold.
  - Owns the overrun decision.
- The deframer FSM stays in `uart_rxser`.

## Test plan
- Reset then idle line → `host_dor`=0, `host_dout`=0x00, `cts`=1, `frame_err`=0, `overrun`=0; stays so for 500 clk.
- Send 0xA5 (8n1, 16 clk/bit) → `host_dor`=1 with `host_dout`=0xA5 one clk after the stop midpoint. Hold `host_rd` high 3 clk then drop → exactly one pop; `host_dor`=0 next clk.
- Send 0x01, 0x02, 0x03 back-to-back, no reads → `cts` drops after the 3rd byte. A 4th byte 0x04 fills the FIFO. A 5th byte 0x55 sets `overrun`. Four reads return 01, 02, 03, 04; `overrun` clears on the first read.
- Frame with stop bit low (0x3C data), then line held low 40 clk → `frame_err`=1, nothing pushed, no new start detected until the line goes high. The next valid 0x7E is received correctly.
- 4-clk low glitch on `serin` → FSM returns to IDLE, nothing pushed, no error flags.
- With the FIFO full, a pop and the stop sample of 0x99 fall on the same clk → count stays 4, `overrun`=0, 0x99 is read last. `reset_b` low mid-DATA → all outputs at reset values next edge; the following frame is received cleanly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states and default rate/FIFO constants.
package uart_pkg;

   localparam int unsigned UART_CLKS_PER_BIT = 16;
   localparam int unsigned UART_FIFO_DEPTH   = 4;

   typedef enum logic [2:0] {
      StIdle,
      StStart,
      StData,
      StStop,
      StWaitHi
   } rx_state_e;

endpackage

// File: rtl/uart_rxfifo.sv
// Receive FIFO with falling-edge state, registered CTS threshold and overrun decision.
module uart_rxfifo
   import uart_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = UART_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       push,
   input  logic [7:0] push_data,
   input  logic       pop,
   output logic [7:0] dout,
   output logic       dor,
   output logic       cts,
   output logic       overrun
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [7:0]      mem_q [FIFO_DEPTH];
   logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0] count_q, count_d;
   logic            cts_q;
   logic            full, empty, pop_ok, push_ok;

   assign full  = (count_q == CntW'(FIFO_DEPTH));
   assign empty = (count_q == '0);

   // A simultaneous pop frees the slot, so a push into a full FIFO is still accepted.
   assign pop_ok  = pop & ~empty;
   assign push_ok = push & (~full | pop_ok);
   assign overrun = push & ~push_ok;

   always_comb begin
      count_d = count_q;
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(negedge clk) begin
      if (!reset_b) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         cts_q    <= 1'b1;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         cts_q   <= (count_d < CntW'(FIFO_DEPTH - 1));
      end
   end

   // Storage is intentionally left unreset.
   always_ff @(negedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= push_data;
   end

   assign dout = empty ? 8'h00 : mem_q[rd_ptr_q];
   assign dor  = ~empty;
   assign cts  = cts_q;

endmodule

// File: rtl/uart_rxser.sv
// UART serial receive front-end: 8n1 deframer, receive FIFO and host read handshake.
module uart_rxser
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
   parameter int unsigned FIFO_DEPTH   = UART_FIFO_DEPTH
) (
   input  logic       clk,
   input  logic       reset_b,
   input  logic       serin,
   input  logic       host_rd,
   output logic [7:0] host_dout,
   output logic       host_dor,
   output logic       cts,
   output logic       frame_err,
   output logic       overrun
);

   localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
   localparam logic [CntW-1:0] MidCnt  = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(CLKS_PER_BIT - 1);

   rx_state_e       state_q, state_d;
   logic [1:0]      sync_q;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shreg_q, shreg_d;
   logic            host_rd_q, frame_err_q, overrun_q;
   logic            rxs, push, ferr_set, rd_pop, fifo_ovr;

   assign rxs    = sync_q[1];
   assign rd_pop = host_rd_q & ~host_rd;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q + 1'b1;
      idx_d    = idx_q;
      shreg_d  = shreg_q;
      push     = 1'b0;
      ferr_set = 1'b0;
      unique case (state_q)
         StIdle: begin
            cnt_d = '0;
            if (!rxs) state_d = StStart;
         end
         StStart: begin
            if (cnt_q == MidCnt) begin
               cnt_d   = '0;
               idx_d   = '0;
               state_d = rxs ? StIdle : StData;
            end
         end
         StData: begin
            if (cnt_q == LastCnt) begin
               cnt_d   = '0;
               shreg_d = {rxs, shreg_q[7:1]};
               idx_d   = idx_q + 3'd1;
               if (idx_q == 3'd7) state_d = StStop;
            end
         end
         StStop: begin
            if (cnt_q == LastCnt) begin
               cnt_d = '0;
               if (rxs) begin
                  push    = 1'b1;
                  state_d = StIdle;
               end else begin
                  ferr_set = 1'b1;
                  state_d  = StWaitHi;
               end
            end
         end
         StWaitHi: begin
            cnt_d = '0;
            if (rxs) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(negedge clk) begin
      if (!reset_b) begin
         sync_q      <= 2'b11;
         state_q     <= StIdle;
         cnt_q       <= '0;
         idx_q       <= '0;
         shreg_q     <= '0;
         host_rd_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         sync_q      <= {sync_q[0], serin};
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         shreg_q     <= shreg_d;
         host_rd_q   <= host_rd;
         // Set beats the read-clear when both land on the same edge.
         frame_err_q <= ferr_set | (frame_err_q & ~rd_pop);
         overrun_q   <= fifo_ovr | (overrun_q & ~rd_pop);
      end
   end

   uart_rxfifo #(
      .FIFO_DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset_b   (reset_b),
      .push      (push),
      .push_data (shreg_q),
      .pop       (rd_pop),
      .dout      (host_dout),
      .dor       (host_dor),
      .cts       (cts),
      .overrun   (fifo_ovr)
   );

   assign frame_err = frame_err_q;
   assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rxser.sv
// Bench for uart_rxser: frame-level scoreboard checked every cycle plus directed literal checks.
module tb_uart_rxser;

   localparam int Depth = 4;
   // Start edge driven after falling edge k is decided at edge k + 2 (sync) + 1 + 8 + 8*16 + 16.
   localparam int StopLat = 155;

   logic       clk = 1'b0;
   logic       reset_b, serin, host_rd;
   logic [7:0] host_dout;
   logic       host_dor, cts, frame_err, overrun;

   always #5 clk = ~clk;

   uart_rxser #(
      .CLKS_PER_BIT(16),
      .FIFO_DEPTH  (Depth)
   ) dut (
      .clk       (clk),
      .reset_b   (reset_b),
      .serin     (serin),
      .host_rd   (host_rd),
      .host_dout (host_dout),
      .host_dor  (host_dor),
      .cts       (cts),
      .frame_err (frame_err),
      .overrun   (overrun)
   );

   int         vectors = 0;
   int         miscompares = 0;
   int         edge_n = 0;
   logic [7:0] push_at [int];
   bit         ferr_at [int];
   logic [7:0] mq [$];
   bit         m_fe, m_ov, m_cts, prev_rd, m_valid;

   // Model: byte queue updated at each falling edge; pop is applied before push.
   initial begin
      m_valid = 1'b0;
      forever begin
         @(negedge clk);
         edge_n++;
         if (!reset_b) begin
            mq.delete();
            m_fe    = 1'b0;
            m_ov    = 1'b0;
            m_cts   = 1'b1;
            prev_rd = 1'b0;
            m_valid = 1'b1;
         end else begin
            if (prev_rd && !host_rd) begin
               if (mq.size() > 0) mq.delete(0);
               m_fe = 1'b0;
               m_ov = 1'b0;
            end
            if (push_at.exists(edge_n)) begin
               if (mq.size() < Depth) mq.push_back(push_at[edge_n]);
               else m_ov = 1'b1;
            end
            if (ferr_at.exists(edge_n)) m_fe = 1'b1;
            m_cts   = (mq.size() < Depth - 1);
            prev_rd = host_rd;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
      end
   endtask

   // Compare process, mid-cycle on the rising edge.
   initial begin
      logic       e_dor;
      logic [7:0] e_dout;
      forever begin
         @(posedge clk);
         if (m_valid) begin
            e_dor  = (mq.size() != 0);
            e_dout = e_dor ? mq[0] : 8'h00;
            chk("cycle dor,dout,cts,fe,ov",
                {20'h0, host_dor, host_dout, cts, frame_err, overrun},
                {20'h0, e_dor, e_dout, m_cts, m_fe, m_ov});
         end
      end
   end

   task automatic wait_edges(input int n);
      repeat (n) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic wait_until(input int e);
      while (edge_n < e) begin
         @(negedge clk);
         #2;
      end
   endtask

   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      int k;
      k = edge_n;
      if (stop_ok) push_at[k + StopLat] = b;
      else ferr_at[k + StopLat] = 1'b1;
      serin = 1'b0;
      wait_edges(16);
      for (int i = 0; i < 8; i++) begin
         serin = b[i];
         wait_edges(16);
      end
      serin = stop_ok;
      wait_edges(16);
   endtask

   task automatic do_read(output logic [7:0] b);
      host_rd = 1'b1;
      b = host_dout;
      wait_edges(3);
      host_rd = 1'b0;
      wait_edges(1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      logic [7:0] rb;
      int         k;
      logic [7:0] exp4 [4];
      serin   = 1'b1;
      host_rd = 1'b0;
      reset_b = 1'b0;
      @(negedge clk);
      #2;
      wait_edges(2);
      reset_b = 1'b1;

      // Idle line after reset
      wait_edges(500);
      chk("idle dor", host_dor, 0);
      chk("idle dout", host_dout, 8'h00);
      chk("idle cts", cts, 1);
      chk("idle frame_err", frame_err, 0);
      chk("idle overrun", overrun, 0);

      // Single byte with exact stop-sample latency
      k = edge_n;
      fork
         send_frame(8'hA5, 1'b1);
         begin
            wait_until(k + StopLat - 1);
            chk("a5 dor before stop", host_dor, 0);
            wait_until(k + StopLat);
            chk("a5 dor at stop", host_dor, 1);
            chk("a5 dout at stop", host_dout, 8'hA5);
         end
      join
      wait_edges(5);
      do_read(rb);
      chk("a5 read", rb, 8'hA5);
      chk("a5 dor after pop", host_dor, 0);

      // Fill the FIFO, then overrun
      send_frame(8'h01, 1'b1);
      send_frame(8'h02, 1'b1);
      chk("cts before 3rd", cts, 1);
      send_frame(8'h03, 1'b1);
      chk("cts after 3rd", cts, 0);
      send_frame(8'h04, 1'b1);
      chk("overrun after 4th", overrun, 0);
      send_frame(8'h55, 1'b1);
      chk("overrun after 5th", overrun, 1);
      for (int i = 0; i < 4; i++) begin
         do_read(rb);
         chk("fifo order", rb, i + 1);
         if (i == 0) chk("overrun cleared by read", overrun, 0);
      end
      chk("fifo drained", host_dor, 0);

      // Framing error followed by a held break
      send_frame(8'h3C, 1'b0);
      wait_edges(40);
      chk("break frame_err", frame_err, 1);
      chk("break nothing pushed", host_dor, 0);
      serin = 1'b1;
      wait_edges(20);
      send_frame(8'h7E, 1'b1);
      do_read(rb);
      chk("7e after break", rb, 8'h7E);
      chk("frame_err cleared by read", frame_err, 0);

      // Short glitch is rejected
      serin = 1'b0;
      wait_edges(4);
      serin = 1'b1;
      wait_edges(40);
      chk("glitch dor", host_dor, 0);
      chk("glitch frame_err", frame_err, 0);

      // Full FIFO: pop and stop sample on the same edge
      send_frame(8'h10, 1'b1);
      send_frame(8'h20, 1'b1);
      send_frame(8'h30, 1'b1);
      send_frame(8'h40, 1'b1);
      k = edge_n;
      fork
         send_frame(8'h99, 1'b1);
         begin
            wait_until(k + StopLat - 4);
            host_rd = 1'b1;
            wait_until(k + StopLat - 1);
            host_rd = 1'b0;
            wait_until(k + StopLat);
            chk("same-edge overrun", overrun, 0);
            chk("same-edge head", host_dout, 8'h20);
         end
      join
      chk("same-edge cts", cts, 0);
      exp4[0] = 8'h20;
      exp4[1] = 8'h30;
      exp4[2] = 8'h40;
      exp4[3] = 8'h99;
      for (int i = 0; i < 4; i++) begin
         do_read(rb);
         chk("same-edge order", rb, exp4[i]);
      end

      // Reset in the middle of a character
      send_frame(8'h11, 1'b1);
      serin = 1'b0;
      wait_edges(16);
      for (int i = 0; i < 3; i++) begin
         serin = i[0] ? 1'b0 : 1'b1;
         wait_edges(16);
      end
      chk("pre-reset dor", host_dor, 1);
      reset_b = 1'b0;
      wait_edges(1);
      chk("reset dor", host_dor, 0);
      chk("reset dout", host_dout, 8'h00);
      chk("reset cts", cts, 1);
      reset_b = 1'b1;
      serin = 1'b1;
      wait_edges(40);
      send_frame(8'hC3, 1'b1);
      do_read(rb);
      chk("post-reset frame", rb, 8'hC3);

      wait_edges(10);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
